hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers. It drives the freeze of the PC and the IF/ID register and the bubble insertion into ID/EX. It compares D-stage register demand (Tuse) against E/M-stage result supply (Tnew), sequences the multi-cycle multiply/divide unit with an internal busy counter, and keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue (1..15)
- DIV_CYCLES, 10, busy cycles after a div/divu issue (1..15)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs_d  in  5  rs field of the D-stage instruction
- rt_d  in  5  rt field of the D-stage instruction
- tuse_rs_d  in  2  cycles until D needs rs (0,1,2); 3 = rs not read
- tuse_rt_d  in  2  same for rt
- a3_e  in  5  destination register of the E-stage instruction (0 = none)
- tnew_e  in  2  cycles until the E-stage result is forwardable (0..2)
- a3_m  in  5  destination register of the M-stage instruction
- tnew_m  in  2  cycles until the M-stage result is forwardable (0..1)
- md_use_d  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_start_e  in  1  an mult/div instruction is in E this cycle (issue pulse)
- md_div_e  in  1  qualifies md_start_e: 1 = divide, 0 = multiply
- stall  out  1  freeze PC and IF/ID (drives FtoD stall)
- flush_e  out  1  load a nop into ID/EX on the next edge
- md_busy  out  1  HI/LO unit busy
- stall_cnt  out  32  saturating count of stalled cycles

## Operation
- Data hazard on rs: rs_d != 0 and tuse_rs_d != 3, and either (rs_d == a3_e and tuse_rs_d < tnew_e) or (rs_d == a3_m and tuse_rs_d < tnew_m). The rt hazard follows the same rule with rt fields.
- MD hazard: md_use_d and md_busy.
- stall = flush_e = data hazard on rs, or on rt, or MD hazard. Both outputs are combinational.
- md_cnt is a 4-bit register. While md_cnt == 0 (IDLE), md_start_e loads DIV_CYCLES if md_div_e is 1, else MULT_CYCLES. While md_cnt != 0 (BUSY), md_cnt decrements by 1 each edge. A md_start_e arriving during BUSY is ignored; it cannot legally occur because the D instruction is held.
- md_busy = md_start_e or (md_cnt != 0).
- stall_cnt increments on every edge where stall = 1. It holds at 32'hFFFFFFFF and never wraps.
- Register 0 never causes a hazard, even when a3_e or a3_m equals 0.

## Timing
- Reset asserted (low), with immediate effect: md_cnt = 0 and stall_cnt = 0. stall, flush_e and md_busy are forced to 0 while reset is low.
- Reset asserted mid-divide aborts the busy sequence. After release the unit is IDLE.
- Hazard outputs have zero latency: a same-cycle input change is reflected in the same cycle.
- md_start_e in cycle T: md_busy is high in T and in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES), and low in T+N+1. A dependent mfhi held in D issues in cycle T+N+1.
- Simultaneous data and MD hazard produce a single stall. stall_cnt increments once per cycle.
- stall_cnt update is visible one edge after the stalled cycle.

## Test plan
- Load-use: rs_d=5, tuse_rs_d=0, a3_e=5, tnew_e=2 -> stall=flush_e=1. Next cycle with a3_m=5, tnew_m=1 -> stall=1. Following cycle, no match -> stall=0. stall_cnt=2.
- No false stall: rs_d=0, a3_e=0, tnew_e=2, tuse=0 -> stall=0. Also tuse_rs_d=3 with rs_d=a3_e=7 -> stall=0.
- Divide then mflo: md_start_e=1, md_div_e=1 at T, then md_use_d=1 held -> stall high for T..T+10, low at T+11. md_busy matches.
- Mult back-to-back: second mult held in D until cycle T+6. Its md_start_e then reloads 5.
- Reset mid-operation: reset low at T+3 of a divide -> md_busy=0, stall=0 and stall_cnt=0 immediately, without a clock edge.
- Saturation: preload by forcing stall for 2^32+3 cycles, or force stall_cnt to 32'hFFFFFFFE, then stall 3 cycles -> stall_cnt = 32'hFFFFFFFF and held.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Purpose : hazard/stall controller for the five-stage core. It compares D-stage Tuse with
//           E/M-stage Tnew, sequences the HI/LO multiply/divide busy window, and counts stalled cycles.
// Latency : stall/flush_e/md_busy are combinational in the same cycle. stall_cnt updates one edge after a stalled cycle.
// Backpr. : stall freezes the PC and IF/ID, and flush_e bubbles ID/EX. A held D instruction re-evaluates every cycle.
// Ports   : clk, reset (async, active-low); rs_d/rt_d + tuse_*_d (D demand);
//           a3_e/tnew_e, a3_m/tnew_m (E/M supply); md_use_d, md_start_e, md_div_e;
//           outputs stall, flush_e, md_busy, stall_cnt[31:0].
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [1:0]  tuse_rs_d,
  input  logic [1:0]  tuse_rt_d,
  input  logic [4:0]  a3_e,
  input  logic [1:0]  tnew_e,
  input  logic [4:0]  a3_m,
  input  logic [1:0]  tnew_m,
  input  logic        md_use_d,
  input  logic        md_start_e,
  input  logic        md_div_e,
  output logic        stall,
  output logic        flush_e,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic [3:0] md_cnt;
  logic       md_idle;
  logic       rs_hz;
  logic       rt_hz;
  logic       md_hz;
  logic       hazard;

  // Tuse of 3 means "operand not read". $0 is hardwired, so a producer
  // that writes $0 never blocks a consumer.
  assign rs_hz = (rs_d != 5'd0) && (tuse_rs_d != 2'd3) &&
                 (((rs_d == a3_e) && (tuse_rs_d < tnew_e)) ||
                  ((rs_d == a3_m) && (tuse_rs_d < tnew_m)));

  assign rt_hz = (rt_d != 5'd0) && (tuse_rt_d != 2'd3) &&
                 (((rt_d == a3_e) && (tuse_rt_d < tnew_e)) ||
                  ((rt_d == a3_m) && (tuse_rt_d < tnew_m)));

  assign md_idle = (md_cnt == 4'd0);

  // The issue pulse itself counts as busy. A dependent HI/LO access in D
  // during the issue cycle is therefore held as well.
  assign md_busy = reset && (md_start_e || !md_idle);
  assign md_hz   = md_use_d && md_busy;

  // Gate with reset so that the outputs drop immediately when reset is asserted, without waiting for an edge.
  assign hazard  = reset && (rs_hz || rt_hz || md_hz);
  assign stall   = hazard;
  assign flush_e = hazard;

  // Busy countdown. An issue while busy cannot happen, because D is held, so it is simply ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (md_idle) begin
      if (md_start_e) begin
        md_cnt <= md_div_e ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end
    end else begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Saturating stall counter. It sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : self-checking bench for hazard_ctrl with a cycle-indexed reference model.
// Latency : checks combinational outputs 1 time unit after inputs change on the falling edge.
// Backpr. : not applicable. The bench drives every input directly.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_d, rt_d, a3_e, a3_m;
  logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic        md_use_d, md_start_e, md_div_e;
  logic        stall, flush_e, md_busy;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference state: current cycle index, last busy cycle of the HI/LO
  // unit, and the saturating stall count.
  longint      cyc = 0;
  longint      busy_end = -1;
  logic [31:0] m_cnt = 0;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .a3_e(a3_e), .tnew_e(tnew_e), .a3_m(a3_m), .tnew_m(tnew_m),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_div_e(md_div_e),
    .stall(stall), .flush_e(flush_e), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hz(input int r, input int tuse, input int ae, input int te,
                            input int am, input int tm);
    if (r == 0 || tuse == 3) return 1'b0;
    return (r == ae && tuse < te) || (r == am && tuse < tm);
  endfunction

  function automatic bit m_idle();
    return cyc > busy_end;
  endfunction

  task automatic neutral();
    rs_d = 0; rt_d = 0; tuse_rs_d = 3; tuse_rt_d = 3;
    a3_e = 0; tnew_e = 0; a3_m = 0; tnew_m = 0;
    md_use_d = 0; md_start_e = 0; md_div_e = 0;
  endtask

  // Call this just after a falling edge with the inputs already driven. It checks
  // the outputs, advances the model by one cycle, and returns after the next falling edge.
  task automatic step(input string tag);
    bit e_busy, e_stall;
    #1;
    e_busy  = md_start_e || !m_idle();
    e_stall = hz(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m) ||
              hz(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m) ||
              (md_use_d && e_busy);
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, e_stall});
    chk({tag, "_flush"}, {31'd0, flush_e}, {31'd0, e_stall});
    chk({tag, "_busy"}, {31'd0, md_busy}, {31'd0, e_busy});
    chk({tag, "_cnt"}, stall_cnt, m_cnt);
    if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (md_start_e && m_idle()) busy_end = cyc + (md_div_e ? DIV_N : MULT_N);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    neutral();
    // Reset is applied while a hazard is presented, so the outputs must stay low.
    reset = 1'b0;
    rs_d = 5; tuse_rs_d = 0; a3_e = 5; tnew_e = 2; md_use_d = 1; md_start_e = 1;
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush_e}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    neutral();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Load-use: a stall while the producer is in E, then in M, then clear.
    rs_d = 5; tuse_rs_d = 0; a3_e = 5; tnew_e = 2; step("lu_e");
    a3_e = 0; tnew_e = 0; a3_m = 5; tnew_m = 1;    step("lu_m");
    a3_m = 0; tnew_m = 0;                          step("lu_clr");
    chk("lu_total", stall_cnt, 32'd2);

    // No false stall on $0 or on an operand that is not read.
    neutral(); rs_d = 0; a3_e = 0; tnew_e = 2; tuse_rs_d = 0; step("r0");
    rs_d = 7; a3_e = 7; tuse_rs_d = 3;                       step("tuse3");
    neutral(); rt_d = 9; tuse_rt_d = 1; a3_m = 9; tnew_m = 1; step("rt_m");
    chk("rt_m_pass", {31'd0, stall}, 32'd0);

    // Divide, then mflo held in D: stalled for 11 cycles, and issues in the 12th.
    neutral();
    base = m_cnt;
    md_start_e = 1; md_div_e = 1; md_use_d = 1; step("div_T");
    md_start_e = 0; md_div_e = 0;
    for (int i = 1; i <= DIV_N; i++) step("div_busy");
    step("div_done");
    chk("div_stalls", stall_cnt - base, 32'd11);

    // Back-to-back multiply: the second waits in D and then re-arms the unit.
    neutral();
    md_start_e = 1; step("mul1_T");
    md_start_e = 0; md_use_d = 1;
    for (int i = 1; i <= MULT_N; i++) step("mul2_held");
    step("mul2_issue");
    md_use_d = 0; md_start_e = 1; step("mul2_E");
    md_start_e = 0;
    for (int i = 1; i <= MULT_N + 1; i++) step("mul2_busy");

    // Reset asserted mid-divide clears everything immediately, without a clock edge.
    neutral();
    md_start_e = 1; md_div_e = 1; md_use_d = 1; step("rdiv_T");
    md_start_e = 0; md_div_e = 0;
    step("rdiv_1"); step("rdiv_2");
    reset = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, md_busy}, 32'd0);
    chk("rmid_stall", {31'd0, stall}, 32'd0);
    chk("rmid_cnt", stall_cnt, 32'd0);
    busy_end = -1; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    step("rmid_idle");

    // Randomized traffic over a small register set, so that matches are frequent.
    for (int i = 0; i < 400; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      tuse_rs_d = 2'($urandom_range(0, 3)); tuse_rt_d = 2'($urandom_range(0, 3));
      a3_e = 5'($urandom_range(0, 3)); tnew_e = 2'($urandom_range(0, 2));
      a3_m = 5'($urandom_range(0, 3)); tnew_m = 2'($urandom_range(0, 1));
      md_use_d = 1'($urandom_range(0, 1));
      md_div_e = 1'($urandom_range(0, 1));
      md_start_e = m_idle() && ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    // Saturation: preload the counter near the top, then stall past it.
    neutral();
    for (int i = 0; i < 12; i++) step("drain");
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFE;
    step("sat_pre");
    rs_d = 5; tuse_rs_d = 0; a3_e = 5; tnew_e = 2;
    for (int i = 0; i < 3; i++) step("sat_stall");
    neutral(); step("sat_hold");
    chk("sat_val", stall_cnt, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
